// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit CR16-style datapath: fetch/decode/execute/memory
// sequencing, datapath control decode, memory handshake watchdog and sticky fault state.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int ALU_OP_W    = 4,
  parameter bit LUI_EN      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic [4:0]          flags,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                ir_en,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_b_imm,
  output logic                imm_zext,
  output logic                flags_we,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                retired,
  output logic                fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_BRANCH = 3'd4,
    S_JUMP   = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam int WD_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int WD_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  // Base ALU opcodes shared by the register form (ext field) and immediate form (op field).
  function automatic logic is_alu_code(input logic [3:0] code);
    case (code)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: is_alu_code = 1'b1;
      default:                                  is_alu_code = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] code);
    case (code)
      4'h5:    alu_code = 4'd0;
      4'h9:    alu_code = 4'd1;
      4'hB:    alu_code = 4'd2;
      4'h1:    alu_code = 4'd3;
      4'h2:    alu_code = 4'd4;
      4'h3:    alu_code = 4'd5;
      4'hD:    alu_code = 4'd6;
      default: alu_code = 4'd0;
    endcase
  endfunction

  // Conditions come in pairs; from group 5 upward the even code is the negated one.
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic n, z, fl, l, cy, base, inv;
    {n, z, fl, l, cy} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = l;
      3'd3:    base = n;
      3'd4:    base = fl;
      3'd5:    base = l | z;
      3'd6:    base = n | z;
      default: base = 1'b0;
    endcase
    if (c[3:1] >= 3'd5) begin
      inv = ~c[0];
    end else begin
      inv = c[0];
    end
    cond_true = base ^ inv;
  endfunction

  state_t              state_r, next_s;
  logic [WD_W-1:0]     wd_r;
  logic                wd_wait_s, wd_expire_s;
  logic [3:0]          op_s, ext_s, cond_s;
  logic                taken_s, unused_s;
  logic                ir_en_s, pc_en_s, rf_we_s, alu_b_imm_s, imm_zext_s, flags_we_s;
  logic                mem_req_s, mem_we_s, addr_sel_s, retired_s, fault_s;
  logic [1:0]          pc_sel_s, wb_sel_s;
  logic [ALU_OP_W-1:0] alu_op_s;

  assign op_s     = instr[15:12];
  assign cond_s   = instr[11:8];
  assign ext_s    = instr[7:4];
  assign unused_s = &{1'b0, instr[3:0]};
  assign taken_s  = cond_true(cond_s, flags);

  assign wd_wait_s   = ((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready;
  assign wd_expire_s = (MEM_TIMEOUT != 0) && wd_wait_s && (wd_r == WD_W'(WD_LAST));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Bus watchdog: counts consecutive unanswered request cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_r <= {WD_W{1'b0}};
    end else if (wd_wait_s && !wd_expire_s) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= {WD_W{1'b0}};
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_s      = state_r;
    ir_en_s     = 1'b0;
    pc_en_s     = 1'b0;
    pc_sel_s    = 2'b00;
    rf_we_s     = 1'b0;
    wb_sel_s    = 2'b00;
    alu_op_s    = {ALU_OP_W{1'b0}};
    alu_b_imm_s = 1'b0;
    imm_zext_s  = 1'b0;
    flags_we_s  = 1'b0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    addr_sel_s  = 1'b0;
    retired_s   = 1'b0;
    fault_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_en_s = 1'b1;
          pc_en_s = 1'b1;
          next_s  = S_DECODE;
        end else if (wd_expire_s) begin
          next_s = S_FAULT;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op_s)
          4'h0: next_s = is_alu_code(ext_s) ? S_EXEC : S_FAULT;
          4'h8: next_s = ((ext_s == 4'h0) || (ext_s == 4'h1) || (ext_s == 4'h4)) ? S_EXEC : S_FAULT;
          4'h4: begin
            case (ext_s)
              4'h0, 4'h4: next_s = S_MEM;
              4'h8, 4'hC: next_s = S_JUMP;
              default:    next_s = S_FAULT;
            endcase
          end
          4'hC:    next_s = S_BRANCH;
          4'hF:    next_s = LUI_EN ? S_EXEC : S_FAULT;
          default: next_s = is_alu_code(op_s) ? S_EXEC : S_FAULT;
        endcase
      end
      S_EXEC: begin
        retired_s = 1'b1;
        next_s    = S_FETCH;
        if (op_s == 4'h0) begin
          alu_op_s   = ALU_OP_W'(alu_code(ext_s));
          flags_we_s = (ext_s == 4'h5) || (ext_s == 4'h9) || (ext_s == 4'hB);
          rf_we_s    = (ext_s != 4'hB);
        end else if (op_s == 4'h8) begin
          alu_op_s    = ALU_OP_W'(4'd7);
          alu_b_imm_s = (ext_s[3:1] == 3'b000);
          rf_we_s     = 1'b1;
        end else if (op_s == 4'hF) begin
          alu_op_s    = ALU_OP_W'(4'd8);
          alu_b_imm_s = 1'b1;
          rf_we_s     = 1'b1;
        end else begin
          alu_op_s    = ALU_OP_W'(alu_code(op_s));
          alu_b_imm_s = 1'b1;
          imm_zext_s  = (op_s == 4'h1) || (op_s == 4'h2) || (op_s == 4'h3);
          flags_we_s  = (op_s == 4'h5) || (op_s == 4'h9) || (op_s == 4'hB);
          rf_we_s     = (op_s != 4'hB);
        end
      end
      S_MEM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = 1'b1;
        mem_we_s   = (ext_s == 4'h4);
        if (mem_ready) begin
          rf_we_s   = (ext_s == 4'h0);
          wb_sel_s  = (ext_s == 4'h0) ? 2'b01 : 2'b00;
          retired_s = 1'b1;
          next_s    = S_FETCH;
        end else if (wd_expire_s) begin
          next_s = S_FAULT;
        end else begin
          next_s = S_MEM;
        end
      end
      S_BRANCH: begin
        retired_s = 1'b1;
        next_s    = S_FETCH;
        if (taken_s) begin
          pc_en_s  = 1'b1;
          pc_sel_s = 2'b01;
        end else begin
          pc_en_s = 1'b0;
        end
      end
      S_JUMP: begin
        retired_s = 1'b1;
        next_s    = S_FETCH;
        if (ext_s == 4'h8) begin
          rf_we_s  = 1'b1;
          wb_sel_s = 2'b10;
          pc_en_s  = 1'b1;
          pc_sel_s = 2'b10;
        end else if (taken_s) begin
          pc_en_s  = 1'b1;
          pc_sel_s = 2'b10;
        end else begin
          pc_en_s = 1'b0;
        end
      end
      S_FAULT: begin
        fault_s = 1'b1;
        next_s  = S_FAULT;
      end
      default: begin
        fault_s = 1'b1;
        next_s  = S_FAULT;
      end
    endcase
  end

  // Reset masks every output combinationally so nothing leaks while it is held.
  assign state     = reset ? 3'd0 : state_r;
  assign ir_en     = ~reset & ir_en_s;
  assign pc_en     = ~reset & pc_en_s;
  assign pc_sel    = reset ? 2'b00 : pc_sel_s;
  assign rf_we     = ~reset & rf_we_s;
  assign wb_sel    = reset ? 2'b00 : wb_sel_s;
  assign alu_op    = reset ? {ALU_OP_W{1'b0}} : alu_op_s;
  assign alu_b_imm = ~reset & alu_b_imm_s;
  assign imm_zext  = ~reset & imm_zext_s;
  assign flags_we  = ~reset & flags_we_s;
  assign mem_req   = ~reset & mem_req_s;
  assign mem_we    = ~reset & mem_we_s;
  assign addr_sel  = ~reset & addr_sel_s;
  assign retired   = ~reset & retired_s;
  assign fault     = ~reset & fault_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed plan cases plus random instructions checked cycle by
// cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [3:0] alu;
    logic       bimm;
    logic       zext;
    logic       fwe;
    logic       mreq;
    logic       mwe;
    logic       asel;
    logic       ret;
    logic       flt;
  } ov_t;

  localparam int K_ALU = 0, K_MEM = 1, K_CTL = 2, K_ILL = 3;
  // Position in this table is the ALU op number.
  localparam logic [3:0] ALU_CODES [7] = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
  localparam logic [3:0] OPS [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8,
                                      4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [4:0]  flags = 5'd0;
  int n_chk = 0, n_fail = 0;

  logic [2:0] a_state, b_state;
  logic a_ir_en, a_pc_en, a_rf_we, a_bimm, a_zext, a_fwe, a_mreq, a_mwe, a_asel, a_ret, a_flt;
  logic b_ir_en, b_pc_en, b_rf_we, b_bimm, b_zext, b_fwe, b_mreq, b_mwe, b_asel, b_ret, b_flt;
  logic [1:0] a_pc_sel, a_wb_sel, b_pc_sel, b_wb_sel;
  logic [3:0] a_alu, b_alu;
  ov_t ova, ovb;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .ALU_OP_W(4), .LUI_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags), .mem_ready(mem_ready),
    .state(a_state), .ir_en(a_ir_en), .pc_en(a_pc_en), .pc_sel(a_pc_sel), .rf_we(a_rf_we),
    .wb_sel(a_wb_sel), .alu_op(a_alu), .alu_b_imm(a_bimm), .imm_zext(a_zext),
    .flags_we(a_fwe), .mem_req(a_mreq), .mem_we(a_mwe), .addr_sel(a_asel),
    .retired(a_ret), .fault(a_flt));

  multicycle_ctrl #(.MEM_TIMEOUT(0), .ALU_OP_W(4), .LUI_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags), .mem_ready(mem_ready),
    .state(b_state), .ir_en(b_ir_en), .pc_en(b_pc_en), .pc_sel(b_pc_sel), .rf_we(b_rf_we),
    .wb_sel(b_wb_sel), .alu_op(b_alu), .alu_b_imm(b_bimm), .imm_zext(b_zext),
    .flags_we(b_fwe), .mem_req(b_mreq), .mem_we(b_mwe), .addr_sel(b_asel),
    .retired(b_ret), .fault(b_flt));

  assign ova = {a_state, a_ir_en, a_pc_en, a_pc_sel, a_rf_we, a_wb_sel, a_alu,
                a_bimm, a_zext, a_fwe, a_mreq, a_mwe, a_asel, a_ret, a_flt};
  assign ovb = {b_state, b_ir_en, b_pc_en, b_pc_sel, b_rf_we, b_wb_sel, b_alu,
                b_bimm, b_zext, b_fwe, b_mreq, b_mwe, b_asel, b_ret, b_flt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (instr %h flags %b): got %h expected %h", tag, instr, flags, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then return just after the next rising edge.
  task automatic cyc(input string tag, input ov_t e, input bit use_b);
    @(negedge clk);
    check(tag, use_b ? 32'(ovb) : 32'(ova), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("reset_a", 32'(ova), 32'd0);
    check("reset_b", 32'(ovb), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference: what the final cycle of an instruction must look like.
  function automatic void classify(input logic [15:0] ins, input bit lui_ok, input logic [4:0] fl,
                                   output int kind, output ov_t e);
    logic [3:0] op, ext, cnd;
    logic n, z, f, l, c;
    logic [15:0] tv;
    int idx;
    bit imm;
    op = ins[15:12]; cnd = ins[11:8]; ext = ins[7:4];
    {n, z, f, l, c} = fl;
    tv = {1'b0, 1'b1, n | z, ~(n | z), l | z, ~(l | z), ~f, f, ~n, n, ~l, l, ~c, c, ~z, z};
    e = '0; e.st = 3'd7; e.flt = 1'b1; kind = K_ILL;
    idx = -1; imm = 1'b0;
    if (op == 4'h0) begin
      for (int k = 0; k < 7; k++) if (ALU_CODES[k] == ext) idx = k;
    end else if (op != 4'h4 && op != 4'h8 && op != 4'hC && op != 4'hF) begin
      for (int k = 0; k < 7; k++) if (ALU_CODES[k] == op) idx = k;
      imm = 1'b1;
    end
    if (idx >= 0) begin
      e = '0; kind = K_ALU; e.st = 3'd2; e.ret = 1'b1; e.alu = 4'(idx);
      e.fwe = (idx <= 2); e.rf_we = (idx != 2); e.bimm = imm;
      e.zext = imm && idx >= 3 && idx <= 5;
    end else if (op == 4'h8 && (ext == 4'h0 || ext == 4'h1 || ext == 4'h4)) begin
      e = '0; kind = K_ALU; e.st = 3'd2; e.ret = 1'b1; e.alu = 4'd7; e.rf_we = 1'b1;
      e.bimm = (ext != 4'h4);
    end else if (op == 4'hF && lui_ok) begin
      e = '0; kind = K_ALU; e.st = 3'd2; e.ret = 1'b1; e.alu = 4'd8; e.rf_we = 1'b1;
      e.bimm = 1'b1;
    end else if (op == 4'h4 && (ext == 4'h0 || ext == 4'h4)) begin
      e = '0; kind = K_MEM; e.st = 3'd3; e.ret = 1'b1; e.mreq = 1'b1; e.asel = 1'b1;
      e.mwe = (ext == 4'h4); e.rf_we = (ext == 4'h0); e.wb_sel = (ext == 4'h0) ? 2'd1 : 2'd0;
    end else if (op == 4'h4 && (ext == 4'h8 || ext == 4'hC)) begin
      e = '0; kind = K_CTL; e.st = 3'd5; e.ret = 1'b1;
      if (ext == 4'h8) begin
        e.rf_we = 1'b1; e.wb_sel = 2'd2; e.pc_en = 1'b1; e.pc_sel = 2'd2;
      end else if (tv[cnd]) begin
        e.pc_en = 1'b1; e.pc_sel = 2'd2;
      end
    end else if (op == 4'hC) begin
      e = '0; kind = K_CTL; e.st = 3'd4; e.ret = 1'b1;
      if (tv[cnd]) begin
        e.pc_en = 1'b1; e.pc_sel = 2'd1;
      end
    end
  endfunction

  task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl, input int fw,
                           input int mw, input bit use_b);
    ov_t e, fin;
    int kind;
    instr = ins;
    flags = fl;
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0; e = '0; e.mreq = 1'b1;
      cyc("fetch_wait", e, use_b);
    end
    mem_ready = 1'b1; e = '0; e.mreq = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1;
    cyc("fetch", e, use_b);
    mem_ready = 1'($urandom_range(0, 1)); e = '0; e.st = 3'd1;
    cyc("decode", e, use_b);
    classify(ins, !use_b, fl, kind, fin);
    if (kind == K_MEM) begin
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0; e = '0; e.st = 3'd3; e.mreq = 1'b1; e.asel = 1'b1; e.mwe = fin.mwe;
        cyc("mem_wait", e, use_b);
      end
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
    cyc("last", fin, use_b);
    if (kind == K_ILL) begin
      mem_ready = 1'b1;
      cyc("fault_hold", fin, use_b);
      do_reset();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ov_t e;
    logic [15:0] r;
    do_reset();
    // Plan cases on the LUI-enabled, MEM_TIMEOUT=4 instance.
    run_instr(16'h0152, 5'b00000, 0, 0, 1'b0);
    run_instr(16'h01B2, 5'b00000, 0, 0, 1'b0);
    run_instr(16'h1380, 5'b00000, 0, 0, 1'b0);
    run_instr(16'hC005, 5'b01000, 0, 0, 1'b0);
    run_instr(16'hC005, 5'b00000, 0, 0, 1'b0);
    run_instr(16'hC0E5, 5'b00000, 0, 0, 1'b0);
    run_instr(16'h4302, 5'b00000, 0, 3, 1'b0);
    run_instr(16'h4342, 5'b00000, 3, 3, 1'b0);
    run_instr(16'h4080, 5'b00000, 0, 0, 1'b0);
    run_instr(16'h4FC0, 5'b00000, 0, 0, 1'b0);
    run_instr(16'hF312, 5'b00000, 0, 0, 1'b0);
    run_instr(16'hE000, 5'b00000, 0, 0, 1'b0);

    // Fetch watchdog: four unanswered cycles, then sticky fault even once ready rises.
    instr = 16'h0152; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = '0; e.mreq = 1'b1; cyc("wd_fetch_wait", e, 1'b0);
    end
    e = '0; e.st = 3'd7; e.flt = 1'b1;
    cyc("wd_fetch_fault", e, 1'b0);
    mem_ready = 1'b1;
    cyc("wd_fault_sticky", e, 1'b0);
    cyc("wd_fault_sticky2", e, 1'b0);
    do_reset();

    // Memory-phase watchdog.
    instr = 16'h4302; mem_ready = 1'b1;
    e = '0; e.mreq = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1; cyc("wdm_fetch", e, 1'b0);
    e = '0; e.st = 3'd1; cyc("wdm_decode", e, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = '0; e.st = 3'd3; e.mreq = 1'b1; e.asel = 1'b1; cyc("wdm_wait", e, 1'b0);
    end
    e = '0; e.st = 3'd7; e.flt = 1'b1; cyc("wdm_fault", e, 1'b0);
    do_reset();

    // Reset pulse while waiting in MEM abandons the load.
    instr = 16'h4302; mem_ready = 1'b1;
    e = '0; e.mreq = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1; cyc("rst_fetch", e, 1'b0);
    e = '0; e.st = 3'd1; cyc("rst_decode", e, 1'b0);
    mem_ready = 1'b0;
    e = '0; e.st = 3'd3; e.mreq = 1'b1; e.asel = 1'b1; cyc("rst_mem", e, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_async", 32'(ova), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_held", 32'(ova), 32'd0);
    reset = 1'b0;
    e = '0; e.mreq = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1; cyc("rst_refetch", e, 1'b0);
    do_reset();

    // LUI disabled and watchdog disabled instance.
    run_instr(16'hF312, 5'b00000, 0, 0, 1'b1);
    run_instr(16'h0152, 5'b00000, 10, 0, 1'b1);
    run_instr(16'h4302, 5'b00000, 2, 10, 1'b1);
    do_reset();

    // Random instructions and flags with short memory waits.
    for (int t = 0; t < 250; t++) begin
      r = 16'($urandom);
      r[15:12] = OPS[$urandom_range(0, 12)];
      if (r[15:12] == 4'h4 && $urandom_range(0, 3) != 0) r[5:4] = 2'b00;
      run_instr(r, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
